get_triangle_angle: RTL and testbench
=====================================

// Module: get_triangle_angle
// PURPOSE
// - Inverse of get_triangle_sides: from legs a (adjacent) and b (opposite), computes
//   hypotenuse and angle in integer degrees.
// - Iterative CORDIC in vectoring mode, one micro-rotation per clock.
// - Used by the vga_cube projection path to recover edge length and orientation from
//   screen-space deltas.
// - Start/busy/done handshake; results held until the next operation completes.
// PARAMETERS
// - WIDTH    32  signed width of a, b, angle, hypotenuse
// - ITER     16  CORDIC micro-rotations (1..16)
// - FRAC     16  fractional bits of internal angle accumulator (degrees, Q.FRAC)
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      reset, asynchronous, active-high
// - start       in   1      request; sampled only in IDLE
// - a           in   WIDTH  signed adjacent leg; captured on accepted start
// - b           in   WIDTH  signed opposite leg; captured on accepted start
// - busy        out  1      high from cycle after accept until done
// - done        out  1      one-cycle pulse when angle/hypotenuse update
// - angle       out  WIDTH  signed degrees, range (-180,180], = round(atan2(b,a))
// - hypotenuse  out  WIDTH  signed, >=0, = round(sqrt(a^2+b^2))
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; busy=0, done=0, angle=0, hypotenuse=0.
// - FSM states: IDLE -> ROTATE -> SCALE -> IDLE.
// - IDLE, start=1 (edge E0):
//   - Capture operands.
//   - Pre-rotate: if a<0, x=-a, y=-b, z=(b>=0 ? +180 : -180)<<FRAC;
//     else x=a, y=b, z=0.
//   - i=0; go ROTATE; busy=1.
// - ROTATE, one step per cycle:
//   - If y>=0: x+=y>>>i, y-=x>>>i, z+=T[i].
//   - Else:    x-=y>>>i, y+=x>>>i, z-=T[i].
//   - Uses the old x/y values; shifts are arithmetic.
//   - T[i] = round(atan(2^-i)*180/pi*2^FRAC), constant ROM (T[0]=45<<FRAC).
//   - After step i=ITER-1, go SCALE.
// - Internal widths:
//   - x, y are WIDTH+2 bits (CORDIC gain ~1.647 plus sign); no overflow for legal inputs.
//   - z is 9+FRAC+1 bits signed.
// - SCALE:
//   - hypotenuse = (x*K + 2^15)>>>16, with K=39797 (0.607253 in Q16).
//   - angle = (z + 2^(FRAC-1))>>>FRAC; an angle result of -180 is output as +180.
//   - done=1 for this one cycle; busy=0; return IDLE.
// - Latency: done asserts on edge E0+ITER+1, i.e. ITER+1 clocks after accept.
//   Back-to-back start is accepted on the edge after done.
// - a==0 and b==0: CORDIC is bypassed in the result.
//   - SCALE outputs angle=0, hypotenuse=0.
//   - Timing still ITER+1.
// - start while busy (ROTATE/SCALE): ignored; operands not recaptured; no queueing.
// - Operand stability: a/b may change after accept without affecting the result.
// - Outputs angle/hypotenuse change only on done cycles; stable otherwise.
// - Legal input range is |a|,|b| < 2^(WIDTH-3).
//   - Outside it results are undefined, but the FSM still completes and returns to IDLE.
// - Accuracy at ITER=16: angle within +/-1 deg of round(atan2), hypotenuse within
//   +/-1 of round(sqrt).
// - Reset mid-operation: aborts immediately; the next start after release behaves as
//   from power-up.
// TESTING
// - a=7,b=7, start 1 cycle -> done exactly 17 clocks later; angle=45, hypotenuse=10.
// - a=17,b=10 -> angle=30, hypotenuse=20.
// - a=-10,b=0 -> angle=180, hypotenuse=10.
// - a=0,b=-30 -> angle=-90, hypotenuse=30.
// - a=0,b=0 -> angle=0, hypotenuse=0, done after 17 clocks.
// - Start held high through op with a/b changed mid-op:
//   - Result matches the originally captured operands.
//   - Second op accepted the cycle after done.
// - Reset asserted at ROTATE i=5:
//   - busy=0, done=0, outputs=0 immediately.
//   - No done pulse follows.
//   - Next op a=3,b=4 -> angle=53, hypotenuse=5.

Source files
------------

// File: rtl/get_triangle_angle.sv
// get_triangle_angle: recovers hypotenuse and integer-degree angle from the
// adjacent (a) and opposite (b) legs using an iterative vectoring CORDIC,
// one micro-rotation per clock, with a start/busy/done handshake.
// Results are held until the next operation completes.
module get_triangle_angle #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] angle,
  output logic [WIDTH-1:0] hypotenuse
);

  // x/y carry GUARD fractional bits below the integer legs so that the
  // truncating arithmetic shifts do not swamp small operands.
  localparam int GUARD = 16;
  localparam int XW    = WIDTH + 2 + GUARD;
  localparam int ZW    = 9 + FRAC + 1;
  localparam int KW    = 18;
  localparam int PW    = XW + KW;

  // 1/CORDIC gain, 0.607253 in Q16.
  localparam logic signed [KW-1:0] K_GAIN   = 18'sd39797;
  localparam logic signed [PW-1:0] HYP_HALF = PW'(1) <<< (15 + GUARD);
  localparam logic signed [ZW-1:0] DEG180   = ZW'(180);
  localparam logic signed [ZW-1:0] Z180     = DEG180 <<< FRAC;
  localparam logic signed [ZW-1:0] Z_HALF   = ZW'(1) <<< (FRAC - 1);
  localparam logic [4:0]           LAST     = 5'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    SCALE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [4:0]              iter_cnt;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [XW-1:0]    a_ext;
  logic signed [XW-1:0]    b_ext;
  logic signed [XW-1:0]    x_acc;
  logic signed [XW-1:0]    y_acc;
  logic signed [XW-1:0]    x_sh;
  logic signed [XW-1:0]    y_sh;
  logic signed [ZW-1:0]    z_acc;
  logic                    zero_op;

  // atan(2^-i) in degrees, held as Q16 and rescaled to Q.FRAC with rounding.
  function automatic logic signed [ZW-1:0] atan_rom(input logic [4:0] idx);
    logic signed [63:0] q16;
    case (idx)
      5'd0:    q16 = 64'sd2949120;
      5'd1:    q16 = 64'sd1740967;
      5'd2:    q16 = 64'sd919879;
      5'd3:    q16 = 64'sd466945;
      5'd4:    q16 = 64'sd234379;
      5'd5:    q16 = 64'sd117304;
      5'd6:    q16 = 64'sd58666;
      5'd7:    q16 = 64'sd29335;
      5'd8:    q16 = 64'sd14668;
      5'd9:    q16 = 64'sd7334;
      5'd10:   q16 = 64'sd3667;
      5'd11:   q16 = 64'sd1833;
      5'd12:   q16 = 64'sd917;
      5'd13:   q16 = 64'sd458;
      5'd14:   q16 = 64'sd229;
      5'd15:   q16 = 64'sd115;
      default: q16 = 64'sd0;
    endcase
    return ZW'(((q16 <<< FRAC) + 64'sd32768) >>> 16);
  endfunction

  // Round the Q.FRAC angle to whole degrees; -180 folds onto +180.
  function automatic logic [WIDTH-1:0] round_angle(input logic signed [ZW-1:0] zv);
    logic signed [ZW-1:0]    deg;
    logic signed [WIDTH-1:0] ext;
    deg = (zv + Z_HALF) >>> FRAC;
    if (deg == -DEG180) begin
      deg = DEG180;
    end
    ext = WIDTH'(deg);
    return ext;
  endfunction

  // Remove the CORDIC gain and the guard bits, rounding to nearest.
  function automatic logic [WIDTH-1:0] round_hyp(input logic signed [XW-1:0] xv);
    logic signed [PW-1:0] prod;
    prod = PW'(xv) * PW'(K_GAIN);
    return WIDTH'((prod + HYP_HALF) >>> (16 + GUARD));
  endfunction

  assign a_s   = a;
  assign b_s   = b;
  assign a_ext = XW'(a_s) <<< GUARD;
  assign b_ext = XW'(b_s) <<< GUARD;
  assign x_sh  = x_acc >>> iter_cnt;
  assign y_sh  = y_acc >>> iter_cnt;
  assign busy  = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one accept, ITER rotations, one scaling cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROTATE;
      ROTATE:  if (iter_cnt == LAST) state_nxt = SCALE;
      SCALE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CORDIC datapath: operand capture with half-plane pre-rotation, then
  // vectoring micro-rotations driving y toward zero.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      zero_op <= (a_s == '0) && (b_s == '0);
      if (a_s < 0) begin
        x_acc <= -a_ext;
        y_acc <= -b_ext;
        z_acc <= (b_s >= 0) ? Z180 : -Z180;
      end else begin
        x_acc <= a_ext;
        y_acc <= b_ext;
        z_acc <= '0;
      end
    end else if (state == ROTATE) begin
      if (!y_acc[XW-1]) begin
        x_acc <= x_acc + y_sh;
        y_acc <= y_acc - x_sh;
        z_acc <= z_acc + atan_rom(iter_cnt);
      end else begin
        x_acc <= x_acc - y_sh;
        y_acc <= y_acc + x_sh;
        z_acc <= z_acc - atan_rom(iter_cnt);
      end
    end
  end

  // Iteration counter, done pulse and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt   <= '0;
      done       <= 1'b0;
      angle      <= '0;
      hypotenuse <= '0;
    end else begin
      done <= (state == SCALE);
      if (state == ROTATE) begin
        iter_cnt <= iter_cnt + 5'd1;
      end else begin
        iter_cnt <= '0;
      end
      if (state == SCALE) begin
        if (zero_op) begin
          angle      <= '0;
          hypotenuse <= '0;
        end else begin
          angle      <= round_angle(z_acc);
          hypotenuse <= round_hyp(x_acc);
        end
      end
    end
  end

endmodule

// File: tb/tb_get_triangle_angle.sv
// Directed bench for get_triangle_angle: table of leg pairs with
// hand-computed angle/hypotenuse, plus held-start and mid-op reset sequences.
module tb_get_triangle_angle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] angle;
  logic [W-1:0] hypotenuse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int va;
    int vb;
    int ang;
    int hyp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  get_triangle_angle #(
    .WIDTH(32),
    .ITER (16),
    .FRAC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .angle     (angle),
    .hypotenuse(hypotenuse)
  );

  task automatic check(input string name, input logic signed [W-1:0] act,
                       input logic signed [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle with the given legs; return clocks from the
  // accepting edge to the edge that raises done (-1 if it never comes).
  task automatic run_op(input int va, input int vb, output int lat);
    start = 1'b1;
    a = va;
    b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Wait for done starting just after an accepting edge.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic seen;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{7, 7, 45, 10};
    vecs[1] = '{17, 10, 30, 20};
    vecs[2] = '{-10, 0, 180, 10};
    vecs[3] = '{0, -30, -90, 30};
    vecs[4] = '{0, 0, 0, 0};
    vecs[5] = '{3, 4, 53, 5};
    vecs[6] = '{-5, -5, -135, 7};
    vecs[7] = '{100, -100, -45, 141};
    vecs[8] = '{-1000, -1, 180, 1000};
    vecs[9] = '{-30000, 40000, 127, 50000};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_angle", angle, 0);
    check("reset_hyp", hypotenuse, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      run_op(vecs[k].va, vecs[k].vb, lat);
      check($sformatf("v%0d_latency", k), lat, 17);
      check($sformatf("v%0d_angle", k), angle, vecs[k].ang);
      check($sformatf("v%0d_hyp", k), hypotenuse, vecs[k].hyp);
      check($sformatf("v%0d_busy_at_done", k), {31'd0, busy}, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", k), {31'd0, done}, 0);
      check($sformatf("v%0d_angle_hold", k), angle, vecs[k].ang);
    end

    // Start held high; operands change right after the accept.
    start = 1'b1;
    a = 17;
    b = 10;
    @(posedge clk); #1;
    check("held_busy_after_accept", {31'd0, busy}, 1);
    a = 3;
    b = 4;
    wait_done(lat);
    check("held_first_latency", lat, 17);
    check("held_first_angle", angle, 30);
    check("held_first_hyp", hypotenuse, 20);
    @(posedge clk); #1;
    check("held_second_accept_busy", {31'd0, busy}, 1);
    check("held_second_done_low", {31'd0, done}, 0);
    start = 1'b0;
    a = -10;
    b = 0;
    wait_done(lat);
    check("held_second_latency", lat, 17);
    check("held_second_angle", angle, 53);
    check("held_second_hyp", hypotenuse, 5);
    @(posedge clk); #1;

    // Reset while the rotation counter sits at 5.
    start = 1'b1;
    a = 100;
    b = -100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset_busy", {31'd0, busy}, 0);
    check("midreset_done", {31'd0, done}, 0);
    check("midreset_angle", angle, 0);
    check("midreset_hyp", hypotenuse, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("midreset_no_done", {31'd0, seen}, 0);
    run_op(3, 4, lat);
    check("after_reset_latency", lat, 17);
    check("after_reset_angle", angle, 53);
    check("after_reset_hyp", hypotenuse, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
